can_bit_destuffer: RTL and testbench

- Bit-stream front end between the bit-timing/sampling logic and `can_receiver`.
- Qualifies each sampled bus bit, detects bus-idle and SOF, and tracks consecutive-equal-bit runs from SOF through the CRC sequence.
- Drives `remove_stuff_bit` for each stuff bit, flags stuff-rule violations, and returns to idle after the end-of-frame recessive run.

---
 rtl/can_bit_destuffer.sv | 207 ++++++++++++++++++++
 tb/tb_can_bit_destuffer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_bit_destuffer.sv
// CAN receive bit-stream front end: bus-idle integration, SOF detection and stuff-bit removal.
// Define CAN_DESTUFF_STATS_EN to add saturating stuff-bit / stuff-error counters.
module can_bit_destuffer #(
  parameter int unsigned IDLE_BITS = 11,
  parameter int unsigned STUFF_LEN = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_point,
  input  logic       rx_bit,
  input  logic       crc_done,
`ifdef CAN_DESTUFF_STATS_EN
  input  logic       stats_clr,
  output logic [7:0] stuff_bit_cnt,
  output logic [7:0] stuff_err_cnt,
`endif
  output logic       rx_bit_curr,
  output logic       bit_valid,
  output logic       remove_stuff_bit,
  output logic       sof_detect,
  output logic       stuff_error,
  output logic       bus_idle
);

  localparam int unsigned RecW = $clog2(IDLE_BITS + 1);
  localparam int unsigned RunW = $clog2(STUFF_LEN + 1);
  localparam logic [RecW-1:0] RecMax = RecW'(IDLE_BITS);
  localparam logic [RunW-1:0] RunMax = RunW'(STUFF_LEN);

  typedef enum logic [2:0] {
    StIntegrate,
    StBusIdle,
    StStuff,
    StFixed,
    StError
  } state_e;

  state_e          state_q, state_d;
  logic [RecW-1:0] rec_cnt_q, rec_cnt_d;
  logic [RunW-1:0] run_cnt_q, run_cnt_d;
  logic            last_bit_q, last_bit_d;
  logic            crc_pend_q, crc_pend_d;
  logic            rx_curr_q, rx_curr_d;
  logic            bit_valid_q, bit_valid_d;
  logic            remove_q, remove_d;
  logic            sof_q, sof_d;
  logic            err_q, err_d;
  logic            rec_full;

  always_comb begin
    state_d     = state_q;
    rec_cnt_d   = rec_cnt_q;
    run_cnt_d   = run_cnt_q;
    last_bit_d  = last_bit_q;
    crc_pend_d  = crc_pend_q;
    rx_curr_d   = rx_curr_q;
    bit_valid_d = 1'b0;
    remove_d    = 1'b0;
    sof_d       = 1'b0;
    err_d       = 1'b0;

    // Recessive run length is tracked in every state; it drives all returns to bus idle.
    if (sample_point) begin
      rx_curr_d = rx_bit;
      if (rx_bit) begin
        if (rec_cnt_q != RecMax) begin
          rec_cnt_d = rec_cnt_q + RecW'(1);
        end
      end else begin
        rec_cnt_d = '0;
      end
    end
    rec_full = sample_point && (rec_cnt_d == RecMax);

    case (state_q)
      StIntegrate: begin
        if (rec_full) begin
          state_d = StBusIdle;
        end
      end

      StBusIdle: begin
        if (sample_point && !rx_bit) begin
          sof_d       = 1'b1;
          bit_valid_d = 1'b1;
          last_bit_d  = 1'b0;
          run_cnt_d   = RunW'(1);
          state_d     = StStuff;
        end
      end

      StStuff: begin
        if (sample_point) begin
          if (run_cnt_q == RunMax) begin
            if (rx_bit != last_bit_q) begin
              remove_d   = 1'b1;
              last_bit_d = rx_bit;
              run_cnt_d  = RunW'(1);
              if (crc_pend_q) begin
                state_d = StFixed;
              end
            end else begin
              err_d   = 1'b1;
              state_d = StError;
            end
          end else begin
            bit_valid_d = 1'b1;
            if (rx_bit == last_bit_q) begin
              run_cnt_d = run_cnt_q + RunW'(1);
            end else begin
              run_cnt_d  = RunW'(1);
              last_bit_d = rx_bit;
            end
          end
        end
        // A run that just reached STUFF_LEN still owes one stuff bit after the CRC.
        if (crc_done && !crc_pend_q && (state_d == StStuff)) begin
          if (run_cnt_d == RunMax) begin
            crc_pend_d = 1'b1;
          end else begin
            state_d = StFixed;
          end
        end
      end

      StFixed: begin
        if (sample_point) begin
          bit_valid_d = 1'b1;
        end
        if (rec_full) begin
          state_d = StBusIdle;
        end
      end

      StError: begin
        if (rec_full) begin
          state_d = StBusIdle;
        end
      end

      default: state_d = StIntegrate;
    endcase

    if (state_d != StStuff) begin
      crc_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIntegrate;
      rec_cnt_q   <= '0;
      run_cnt_q   <= '0;
      last_bit_q  <= 1'b1;
      crc_pend_q  <= 1'b0;
      rx_curr_q   <= 1'b1;
      bit_valid_q <= 1'b0;
      remove_q    <= 1'b0;
      sof_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rec_cnt_q   <= rec_cnt_d;
      run_cnt_q   <= run_cnt_d;
      last_bit_q  <= last_bit_d;
      crc_pend_q  <= crc_pend_d;
      rx_curr_q   <= rx_curr_d;
      bit_valid_q <= bit_valid_d;
      remove_q    <= remove_d;
      sof_q       <= sof_d;
      err_q       <= err_d;
    end
  end

  assign rx_bit_curr      = rx_curr_q;
  assign bit_valid        = bit_valid_q;
  assign remove_stuff_bit = remove_q;
  assign sof_detect       = sof_q;
  assign stuff_error      = err_q;
  assign bus_idle         = (state_q == StBusIdle);

`ifdef CAN_DESTUFF_STATS_EN
  logic [7:0] sb_cnt_q, se_cnt_q;

  // Counters advance on the same edge that raises the matching strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_cnt_q <= 8'd0;
      se_cnt_q <= 8'd0;
    end else if (stats_clr) begin
      sb_cnt_q <= 8'd0;
      se_cnt_q <= 8'd0;
    end else begin
      if (remove_d && (sb_cnt_q != 8'hFF)) begin
        sb_cnt_q <= sb_cnt_q + 8'd1;
      end
      if (err_d && (se_cnt_q != 8'hFF)) begin
        se_cnt_q <= se_cnt_q + 8'd1;
      end
    end
  end

  assign stuff_bit_cnt = sb_cnt_q;
  assign stuff_err_cnt = se_cnt_q;
`endif

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Randomized frame-level bench for can_bit_destuffer against a queue-based reference model.
// Build with CAN_DESTUFF_STATS_EN defined to also check the statistics counters.
module tb_can_bit_destuffer;

  localparam int unsigned IDLE_BITS = 11;
  localparam int unsigned STUFF_LEN = 5;
  localparam int MInt = 0, MIdle = 1, MStuff = 2, MFixed = 3, MErr = 4;

  logic clk = 1'b0;
  logic rst, sample_point, rx_bit, crc_done;
  logic rx_bit_curr, bit_valid, remove_stuff_bit, sof_detect, stuff_error, bus_idle;
`ifdef CAN_DESTUFF_STATS_EN
  logic       stats_clr;
  logic [7:0] stuff_bit_cnt, stuff_err_cnt;
  int         m_sb, m_se;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: bus history and frame bit history, runs derived by counting.
  int mode;
  bit pend;
  bit hist[$];
  bit frame[$];
  bit e_curr, e_bv, e_rm, e_sof, e_err;

  always #5 clk = ~clk;

  can_bit_destuffer #(
    .IDLE_BITS(IDLE_BITS),
    .STUFF_LEN(STUFF_LEN)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sample_point    (sample_point),
    .rx_bit          (rx_bit),
    .crc_done        (crc_done),
`ifdef CAN_DESTUFF_STATS_EN
    .stats_clr       (stats_clr),
    .stuff_bit_cnt   (stuff_bit_cnt),
    .stuff_err_cnt   (stuff_err_cnt),
`endif
    .rx_bit_curr     (rx_bit_curr),
    .bit_valid       (bit_valid),
    .remove_stuff_bit(remove_stuff_bit),
    .sof_detect      (sof_detect),
    .stuff_error     (stuff_error),
    .bus_idle        (bus_idle)
  );

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int trail_ones();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (!hist[i]) break;
      n++;
    end
    return n;
  endfunction

  function automatic int trail_eq();
    int n = 0;
    if (frame.size() == 0) return 0;
    for (int i = frame.size() - 1; i >= 0; i--) begin
      if (frame[i] != frame[frame.size()-1]) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    mode = MInt;
    pend = 1'b0;
    hist.delete();
    frame.delete();
    e_curr = 1'b1;
    e_bv = 1'b0; e_rm = 1'b0; e_sof = 1'b0; e_err = 1'b0;
`ifdef CAN_DESTUFF_STATS_EN
    m_sb = 0;
    m_se = 0;
`endif
  endtask

  task automatic push_frame(input bit b);
    frame.push_back(b);
    if (frame.size() > 8) void'(frame.pop_front());
  endtask

  task automatic model_step(input bit sp, input bit b, input bit crc);
    bit full;
    e_bv = 1'b0; e_rm = 1'b0; e_sof = 1'b0; e_err = 1'b0;
    if (sp) begin
      e_curr = b;
      hist.push_back(b);
      if (hist.size() > IDLE_BITS) void'(hist.pop_front());
    end
    full = sp && (trail_ones() == IDLE_BITS);
    case (mode)
      MInt: if (full) mode = MIdle;
      MIdle: begin
        if (sp && !b) begin
          e_sof = 1'b1;
          e_bv  = 1'b1;
          frame.delete();
          push_frame(1'b0);
          mode = MStuff;
        end
      end
      MStuff: begin
        if (sp) begin
          if (trail_eq() == STUFF_LEN) begin
            if (b != frame[frame.size()-1]) begin
              e_rm = 1'b1;
              push_frame(b);
              if (pend) mode = MFixed;
            end else begin
              e_err = 1'b1;
              mode  = MErr;
            end
          end else begin
            e_bv = 1'b1;
            push_frame(b);
          end
        end
        if (crc && !pend && mode == MStuff) begin
          if (trail_eq() == STUFF_LEN) pend = 1'b1;
          else mode = MFixed;
        end
      end
      MFixed: begin
        e_bv = sp;
        if (full) mode = MIdle;
      end
      default: if (full) mode = MIdle;
    endcase
    if (mode != MStuff) pend = 1'b0;
`ifdef CAN_DESTUFF_STATS_EN
    if (stats_clr) begin
      m_sb = 0;
      m_se = 0;
    end else begin
      if (e_rm && m_sb < 255) m_sb++;
      if (e_err && m_se < 255) m_se++;
    end
`endif
  endtask

  task automatic compare_all();
    check_eq("rx_bit_curr", 8'(rx_bit_curr), 8'(e_curr));
    check_eq("bit_valid", 8'(bit_valid), 8'(e_bv));
    check_eq("remove_stuff_bit", 8'(remove_stuff_bit), 8'(e_rm));
    check_eq("sof_detect", 8'(sof_detect), 8'(e_sof));
    check_eq("stuff_error", 8'(stuff_error), 8'(e_err));
    check_eq("bus_idle", 8'(bus_idle), 8'(mode == MIdle));
`ifdef CAN_DESTUFF_STATS_EN
    check_eq("stuff_bit_cnt", stuff_bit_cnt, 8'(m_sb));
    check_eq("stuff_err_cnt", stuff_err_cnt, 8'(m_se));
`endif
  endtask

  task automatic cyc(input bit sp, input bit b, input bit crc);
    @(negedge clk);
    sample_point = sp;
    rx_bit       = b;
    crc_done     = crc;
`ifdef CAN_DESTUFF_STATS_EN
    stats_clr = ($urandom_range(0, 149) == 0);
`endif
    @(posedge clk);
    model_step(sp, b, crc);
    #1;
    compare_all();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    sample_point = 1'b0;
    crc_done     = 1'b0;
    rst          = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Sample-free cycles; crc_done noise only where it must be ignored.
  task automatic gap(input bit noisy);
    repeat ($urandom_range(0, 2)) cyc(1'b0, 1'($urandom), noisy && ($urandom_range(0, 3) == 0));
  endtask

  task automatic send_idle();
    int n = 0;
    while (mode != MIdle && n < 40) begin
      gap(mode != MStuff);
      cyc(1'b1, 1'b1, 1'b0);
      n++;
    end
    if (mode != MIdle) check_eq("idle_timeout", 8'(bus_idle), 8'd1);
  endtask

  task automatic send_frame();
    int len    = $urandom_range(8, 60);
    int rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, len - 1) : -1;
    int grun   = 1;
    bit glast  = 1'b0;
    bit b, crc_now;
    bit done   = 1'b0;
    bit crc_sent = 1'b0;
    send_idle();
    cyc(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < len && !done; k++) begin
      gap(1'b0);
      if (k == rst_at) begin
        pulse_reset();
        return;
      end
      if (grun == STUFF_LEN) begin
        b = ($urandom_range(0, 39) == 0) ? glast : !glast;
        if (b == glast) done = 1'b1;
        grun  = 1;
        glast = b;
        cyc(1'b1, b, 1'b0);
      end else begin
        b = ($urandom_range(0, 2) == 0) ? !glast : glast;
        if (b == glast) grun++;
        else begin
          grun  = 1;
          glast = b;
        end
        crc_now = (k == len - 1) && $urandom_range(0, 1);
        if (crc_now) crc_sent = 1'b1;
        cyc(1'b1, b, crc_now);
      end
    end
    if (!done) begin
      if (!crc_sent) begin
        gap(1'b0);
        cyc(1'b0, 1'b1, 1'b1);
      end
      if (grun == STUFF_LEN) begin
        gap(1'b0);
        cyc(1'b1, ($urandom_range(0, 3) == 0) ? glast : !glast, 1'b0);
      end
    end
    repeat (12 + $urandom_range(0, 3)) begin
      gap(1'b1);
      cyc(1'b1, 1'b1, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    sample_point = 1'b0;
    rx_bit       = 1'b1;
    crc_done     = 1'b0;
`ifdef CAN_DESTUFF_STATS_EN
    stats_clr = 1'b0;
`endif
    model_reset();
    #1;
    check_eq("reset_rx_bit_curr", 8'(rx_bit_curr), 8'd1);
    check_eq("reset_bus_idle", 8'(bus_idle), 8'd0);
    check_eq("reset_strobes",
             8'({bit_valid, remove_stuff_bit, sof_detect, stuff_error}), 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Integration: 10 recessive bits are not enough, the 11th is.
    repeat (10) cyc(1'b1, 1'b1, 1'b0);
    check_eq("idle_after_10", 8'(bus_idle), 8'd0);
    cyc(1'b1, 1'b1, 1'b0);
    check_eq("idle_after_11", 8'(bus_idle), 8'd1);

    // SOF, five recessive, stuff 0, then data 1.
    cyc(1'b1, 1'b0, 1'b0);
    check_eq("sof_strobe", 8'(sof_detect), 8'd1);
    repeat (5) begin
      cyc(1'b1, 1'b1, 1'b0);
      check_eq("run_bit_valid", 8'(bit_valid), 8'd1);
    end
    cyc(1'b1, 1'b0, 1'b0);
    check_eq("stuff_removed", 8'(remove_stuff_bit), 8'd1);
    check_eq("stuff_not_valid", 8'(bit_valid), 8'd0);
    cyc(1'b1, 1'b1, 1'b0);
    check_eq("post_stuff_valid", 8'(bit_valid), 8'd1);
    send_idle();

    // Six equal dominant bits from SOF: stuff error, then silence until idle.
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check_eq("stuff_err_strobe", 8'(stuff_error), 8'd1);
    repeat (10) begin
      cyc(1'b1, 1'b1, 1'b0);
      check_eq("err_no_valid", 8'(bit_valid), 8'd0);
    end
    check_eq("err_not_idle_10", 8'(bus_idle), 8'd0);
    cyc(1'b1, 1'b1, 1'b0);
    check_eq("err_idle_11", 8'(bus_idle), 8'd1);

    // crc_done at run 5: opposite bit is still destuffed, then fixed form.
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    check_eq("crc_pend_stuff", 8'(remove_stuff_bit), 8'd1);
    repeat (6) begin
      cyc(1'b1, 1'b1, 1'b0);
      check_eq("fixed_no_err", 8'(stuff_error), 8'd0);
    end
    send_idle();
    // Same, but crc_done with the fifth bit and an equal follow-up bit.
    repeat (4) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    check_eq("crc_pend_err", 8'(stuff_error), 8'd1);
    send_idle();

    // Reset mid-frame, then SOF is refused before 11 recessive bits.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    pulse_reset();
    repeat (10) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check_eq("no_early_sof", 8'(sof_detect), 8'd0);

    for (int f = 0; f < 60; f++) send_frame();
    send_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
